// File: rtl/trap_ctrl.sv
`timescale 1ns/1ps
// trap_ctrl: machine-mode trap/mret sequencer that writes mepc/mcause and redirects fetch.
// Define TRAP_CTRL_MTVAL_EN to add an mtval write after mcause.
module trap_ctrl #(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            req_valid_i,
  output logic            req_ready_o,
  input  logic [1:0]      req_kind_i,
  input  logic [XLEN-1:0] req_pc_i,
  input  logic [XLEN-1:0] req_instr_i,
  output logic            csr_wen_o,
  output logic [11:0]     csr_id_o,
  output logic [XLEN-1:0] csr_wdata_o,
  input  logic [XLEN-1:0] csr_mtvec_i,
  input  logic [XLEN-1:0] csr_mepc_i,
  output logic            redir_valid_o,
  output logic [XLEN-1:0] redir_pc_o,
  input  logic            redir_ready_i,
  output logic            flush_o
);
  localparam logic [1:0] KIND_ECALL   = 2'b00;
  localparam logic [1:0] KIND_EBREAK  = 2'b01;
  localparam logic [1:0] KIND_ILLEGAL = 2'b10;
  localparam logic [1:0] KIND_MRET    = 2'b11;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    SAVE_EPC   = 3'd1,
    SAVE_CAUSE = 3'd2,
`ifdef TRAP_CTRL_MTVAL_EN
    SAVE_TVAL  = 3'd3,
`endif
    REDIRECT   = 3'd4,
    RETURN     = 3'd5
  } state_e;

  state_e          state_q, state_d;
  logic [1:0]      kind_q, kind_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            accept;
`ifdef TRAP_CTRL_MTVAL_EN
  logic [XLEN-1:0] instr_q, instr_d;
`else
  logic            unused_instr;
  assign unused_instr = ^req_instr_i;
`endif
  // Redirect targets are always word aligned, so the low tvec/epc bits are dropped.
  logic            unused_low_bits;
  assign unused_low_bits = ^{csr_mtvec_i[1:0], csr_mepc_i[1:0]};

  function automatic logic [XLEN-1:0] cause_code(input logic [1:0] kind);
    logic [XLEN-1:0] c;
    c = '0;
    case (kind)
      KIND_ECALL:   c[3:0] = 4'd11;
      KIND_EBREAK:  c[3:0] = 4'd3;
      KIND_ILLEGAL: c[3:0] = 4'd2;
      default:      c = '0;
    endcase
    return c;
  endfunction

`ifdef TRAP_CTRL_MTVAL_EN
  function automatic logic [XLEN-1:0] tval_value(input logic [1:0] kind,
                                                 input logic [XLEN-1:0] pc,
                                                 input logic [XLEN-1:0] instr);
    logic [XLEN-1:0] v;
    case (kind)
      KIND_ILLEGAL: v = instr;
      KIND_EBREAK:  v = pc;
      default:      v = '0;
    endcase
    return v;
  endfunction
`endif

  always_comb begin
    state_d       = state_q;
    kind_d        = kind_q;
    pc_d          = pc_q;
`ifdef TRAP_CTRL_MTVAL_EN
    instr_d       = instr_q;
`endif
    accept        = 1'b0;
    req_ready_o   = 1'b0;
    csr_wen_o     = 1'b0;
    csr_id_o      = '0;
    csr_wdata_o   = '0;
    redir_valid_o = 1'b0;
    redir_pc_o    = '0;
    flush_o       = (state_q != IDLE);
    case (state_q)
      IDLE: begin
        // Ready is gated by reset so it reads 0 while rst_ni is held low.
        req_ready_o = rst_ni;
        accept      = req_valid_i & rst_ni;
        if (accept) begin
          kind_d  = req_kind_i;
          pc_d    = req_pc_i;
`ifdef TRAP_CTRL_MTVAL_EN
          instr_d = req_instr_i;
`endif
          state_d = (req_kind_i == KIND_MRET) ? RETURN : SAVE_EPC;
        end
      end
      SAVE_EPC: begin
        csr_wen_o   = 1'b1;
        csr_id_o    = 12'h341;
        csr_wdata_o = pc_q;
        state_d     = SAVE_CAUSE;
      end
      SAVE_CAUSE: begin
        csr_wen_o   = 1'b1;
        csr_id_o    = 12'h342;
        csr_wdata_o = cause_code(kind_q);
`ifdef TRAP_CTRL_MTVAL_EN
        state_d     = SAVE_TVAL;
`else
        state_d     = REDIRECT;
`endif
      end
`ifdef TRAP_CTRL_MTVAL_EN
      SAVE_TVAL: begin
        csr_wen_o   = 1'b1;
        csr_id_o    = 12'h343;
        csr_wdata_o = tval_value(kind_q, pc_q, instr_q);
        state_d     = REDIRECT;
      end
`endif
      REDIRECT: begin
        redir_valid_o = 1'b1;
        redir_pc_o    = {csr_mtvec_i[XLEN-1:2], 2'b00};
        if (redir_ready_i) state_d = IDLE;
      end
      RETURN: begin
        redir_valid_o = 1'b1;
        redir_pc_o    = {csr_mepc_i[XLEN-1:2], 2'b00};
        if (redir_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Request payload registers carry no reset; they are only read after an accept.
  always_ff @(posedge clk_i) begin
    kind_q  <= kind_d;
    pc_q    <= pc_d;
`ifdef TRAP_CTRL_MTVAL_EN
    instr_q <= instr_d;
`endif
  end
endmodule

// File: tb/tb_trap_ctrl.sv
`timescale 1ns/1ps
// Bench for trap_ctrl: transaction-level expected-event model checked every cycle, plus directed literal checks.
module tb_trap_ctrl;
  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        req_valid_i;
  logic        req_ready_o;
  logic [1:0]  req_kind_i;
  logic [31:0] req_pc_i, req_instr_i;
  logic        csr_wen_o;
  logic [11:0] csr_id_o;
  logic [31:0] csr_wdata_o;
  logic [31:0] csr_mtvec_i, csr_mepc_i;
  logic        redir_valid_o;
  logic [31:0] redir_pc_o;
  logic        redir_ready_i;
  logic        flush_o;

  trap_ctrl #(.XLEN(32)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_kind_i(req_kind_i), .req_pc_i(req_pc_i), .req_instr_i(req_instr_i),
    .csr_wen_o(csr_wen_o), .csr_id_o(csr_id_o), .csr_wdata_o(csr_wdata_o),
    .csr_mtvec_i(csr_mtvec_i), .csr_mepc_i(csr_mepc_i),
    .redir_valid_o(redir_valid_o), .redir_pc_o(redir_pc_o),
    .redir_ready_i(redir_ready_i), .flush_o(flush_o)
  );

  always #5 clk_i = ~clk_i;

`ifdef TRAP_CTRL_MTVAL_EN
  localparam int TRAP_WRITES = 3;
`else
  localparam int TRAP_WRITES = 2;
`endif

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Model: an accepted request becomes a list of CSR writes to emit one per cycle,
  // followed by one pending redirect that ends on the first cycle fetch is ready.
  logic [11:0] exp_id_q[$];
  logic [31:0] exp_data_q[$];
  bit          redir_pend = 0;
  bit          redir_is_ret = 0;

  function automatic logic [31:0] cause_of(input logic [1:0] k);
    case (k)
      2'd0:    return 32'd11;
      2'd1:    return 32'd3;
      default: return 32'd2;
    endcase
  endfunction

  always @(negedge clk_i) begin
    logic        e_rr, e_wen, e_rv, e_fl;
    logic [11:0] e_id;
    logic [31:0] e_wd, e_pc;
    e_rr = 0; e_wen = 0; e_rv = 0; e_fl = 0; e_id = '0; e_wd = '0; e_pc = '0;
    if (!rst_ni) begin
      exp_id_q.delete();
      exp_data_q.delete();
      redir_pend = 0;
    end else begin
      e_fl = (exp_id_q.size() > 0) || redir_pend;
      if (exp_id_q.size() > 0) begin
        e_wen = 1;
        e_id  = exp_id_q.pop_front();
        e_wd  = exp_data_q.pop_front();
      end else if (redir_pend) begin
        e_rv = 1;
        e_pc = (redir_is_ret ? csr_mepc_i : csr_mtvec_i) & 32'hFFFF_FFFC;
        if (redir_ready_i) redir_pend = 0;
      end else begin
        e_rr = 1;
        if (req_valid_i) begin
          redir_pend   = 1;
          redir_is_ret = (req_kind_i == 2'd3);
          if (!redir_is_ret) begin
            exp_id_q.push_back(12'h341); exp_data_q.push_back(req_pc_i);
            exp_id_q.push_back(12'h342); exp_data_q.push_back(cause_of(req_kind_i));
`ifdef TRAP_CTRL_MTVAL_EN
            exp_id_q.push_back(12'h343);
            exp_data_q.push_back(req_kind_i == 2'd2 ? req_instr_i :
                                 req_kind_i == 2'd1 ? req_pc_i : 32'd0);
`endif
          end
        end
      end
    end
    chk("m_req_ready", {31'd0, req_ready_o}, {31'd0, e_rr});
    chk("m_csr_wen", {31'd0, csr_wen_o}, {31'd0, e_wen});
    chk("m_csr_id", {20'd0, csr_id_o}, {20'd0, e_id});
    chk("m_csr_wdata", csr_wdata_o, e_wd);
    chk("m_redir_valid", {31'd0, redir_valid_o}, {31'd0, e_rv});
    chk("m_redir_pc", redir_pc_o, e_pc);
    chk("m_flush", {31'd0, flush_o}, {31'd0, e_fl});
  end

  task automatic tick;
    @(posedge clk_i); #1;
  endtask

  task automatic at_neg;
    @(negedge clk_i); #1;
  endtask

  task automatic send(input logic [1:0] k, input logic [31:0] pc, input logic [31:0] ins);
    req_valid_i = 1; req_kind_i = k; req_pc_i = pc; req_instr_i = ins;
    at_neg;
    chk("accept_ready", {31'd0, req_ready_o}, 32'd1);
    tick;
    req_valid_i = 0;
  endtask

  task automatic exp_write(input string name, input logic [11:0] id, input logic [31:0] d);
    at_neg;
    chk({name, "_wen"}, {31'd0, csr_wen_o}, 32'd1);
    chk({name, "_id"}, {20'd0, csr_id_o}, {20'd0, id});
    chk({name, "_data"}, csr_wdata_o, d);
    tick;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, a1, a2;
    bit acc;
    rst_ni = 0; req_valid_i = 0; req_kind_i = 0; req_pc_i = 0; req_instr_i = 0;
    csr_mtvec_i = 0; csr_mepc_i = 0; redir_ready_i = 0;
    #1;
    chk("rst_ready", {31'd0, req_ready_o}, 32'd0);
    chk("rst_flush", {31'd0, flush_o}, 32'd0);
    tick; tick;
    rst_ni = 1;
    at_neg;
    chk("post_rst_ready", {31'd0, req_ready_o}, 32'd1);
    tick;

    // ecall, fetch ready immediately
    redir_ready_i = 1; csr_mtvec_i = 32'h8000_0103;
    send(2'd0, 32'h8000_0010, 32'h0000_0073);
    exp_write("t1_epc", 12'h341, 32'h8000_0010);
    exp_write("t1_cause", 12'h342, 32'd11);
`ifdef TRAP_CTRL_MTVAL_EN
    exp_write("t1_tval", 12'h343, 32'd0);
`endif
    at_neg;
    chk("t1_redir_valid", {31'd0, redir_valid_o}, 32'd1);
    chk("t1_redir_pc", redir_pc_o, 32'h8000_0100);
    tick;
    at_neg;
    chk("t1_idle_ready", {31'd0, req_ready_o}, 32'd1);
    chk("t1_idle_flush", {31'd0, flush_o}, 32'd0);
    tick;

    // mret
    csr_mepc_i = 32'h8000_0014;
    send(2'd3, 32'h8000_0100, 32'h3020_0073);
    at_neg;
    chk("t2_redir_pc", redir_pc_o, 32'h8000_0014);
    chk("t2_no_wen", {31'd0, csr_wen_o}, 32'd0);
    tick;
    at_neg;
    chk("t2_idle_ready", {31'd0, req_ready_o}, 32'd1);
    tick;

    // illegal with fetch stalling five cycles
    redir_ready_i = 0;
    send(2'd2, 32'h0000_0040, 32'hFFFF_FFFF);
    exp_write("t3_epc", 12'h341, 32'h0000_0040);
    exp_write("t3_cause", 12'h342, 32'd2);
`ifdef TRAP_CTRL_MTVAL_EN
    exp_write("t3_tval", 12'h343, 32'hFFFF_FFFF);
`endif
    for (int i = 0; i < 5; i++) begin
      at_neg;
      chk("t3_hold_valid", {31'd0, redir_valid_o}, 32'd1);
      chk("t3_hold_ready", {31'd0, req_ready_o}, 32'd0);
      tick;
    end
    redir_ready_i = 1;
    at_neg;
    chk("t3_redir_valid", {31'd0, redir_valid_o}, 32'd1);
    tick;

    // ebreak
    send(2'd1, 32'h0000_0200, 32'h0010_0073);
    exp_write("t4_epc", 12'h341, 32'h0000_0200);
    exp_write("t4_cause", 12'h342, 32'd3);
`ifdef TRAP_CTRL_MTVAL_EN
    exp_write("t4_tval", 12'h343, 32'h0000_0200);
`endif
    tick;

    // reset during SAVE_CAUSE
    send(2'd0, 32'h0000_1000, 32'h0);
    exp_write("t5_epc", 12'h341, 32'h0000_1000);
    rst_ni = 0;
    #1;
    chk("t5_rst_wen", {31'd0, csr_wen_o}, 32'd0);
    chk("t5_rst_id", {20'd0, csr_id_o}, 32'd0);
    chk("t5_rst_flush", {31'd0, flush_o}, 32'd0);
    chk("t5_rst_ready", {31'd0, req_ready_o}, 32'd0);
    tick; tick;
    rst_ni = 1;
    at_neg;
    chk("t5_post_ready", {31'd0, req_ready_o}, 32'd1);
    chk("t5_post_redir", {31'd0, redir_valid_o}, 32'd0);
    tick;
    send(2'd0, 32'h0000_2000, 32'h0);
    repeat (6) tick;

    // valid held across two ecalls
    req_valid_i = 1; req_kind_i = 2'd0; req_pc_i = 32'h0000_0300;
    n = 0; a1 = 0; a2 = 0;
    for (int i = 0; i < 40 && n < 2; i++) begin
      at_neg;
      if (req_ready_o) begin
        if (n == 0) a1 = i; else a2 = i;
        n++;
      end
      tick;
      if (n == 1) req_pc_i = 32'h0000_0304;
    end
    req_valid_i = 0;
    chk("t6_accepts", n, 32'd2);
    chk("t6_gap", a2 - a1, TRAP_WRITES + 2);
    repeat (8) tick;

    // randomized traffic with occasional reset
    for (int i = 0; i < 3000; i++) begin
      at_neg;
      acc = req_valid_i && req_ready_o;
      tick;
      rst_ni = ($urandom_range(0, 99) != 0);
      if (!req_valid_i || acc) begin
        req_valid_i = ($urandom_range(0, 2) != 0);
        req_kind_i  = 2'($urandom_range(0, 3));
        req_pc_i    = $urandom;
        req_instr_i = $urandom;
      end
      redir_ready_i = ($urandom_range(0, 3) != 0);
      csr_mtvec_i   = $urandom;
      csr_mepc_i    = $urandom;
    end
    rst_ni = 1;
    repeat (4) tick;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
